// File: rtl/blend_pkg.sv
// Shared types and constants for the streaming pixel blender.
package blend_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    BM_ADD_SAT = 2'd0,
    BM_SUB_SAT = 2'd1,
    BM_AVG     = 2'd2,
    BM_ALPHA   = 2'd3
  } blend_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } blend_state_e;

endpackage

// File: rtl/stream_pixel_blend_if.sv
// Paired-pixel input stream and blended output stream of the blender.
interface stream_pixel_blend_if #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned CHANNELS = 1
);
    logic                      s_valid;
    logic                      s_ready;
    logic [CHANNELS*PIX_W-1:0] orig_pix;
    logic [CHANNELS*PIX_W-1:0] sharp_pix;
    logic                      m_valid;
    logic                      m_ready;
    logic [CHANNELS*PIX_W-1:0] m_pix;
    logic                      m_eol;
    logic                      m_eof;

    // Block-side view.
    modport slave (
        input  s_valid, orig_pix, sharp_pix, m_ready,
        output s_ready, m_valid, m_pix, m_eol, m_eof
    );

    // Environment-side view.
    modport master (
        output s_valid, orig_pix, sharp_pix, m_ready,
        input  s_ready, m_valid, m_pix, m_eol, m_eof
    );
endinterface

// File: rtl/blend_channel_alu.sv
// Single-channel blend arithmetic: stage 1 registers operands/products,
// stage 2 registers the add/shift/clamp result.
module blend_channel_alu
    import blend_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned ALPHA_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load1,
    input  logic               load2,
    input  logic [MODE_W-1:0]  mode,
    input  logic [ALPHA_W-1:0] alpha,
    input  logic [PIX_W-1:0]   orig,
    input  logic [PIX_W-1:0]   sharp,
    output logic [PIX_W-1:0]   result
);
    localparam int unsigned W = PIX_W + ALPHA_W + 1;
    localparam logic [W-1:0] MAX    = W'({PIX_W{1'b1}});
    localparam logic [W-1:0] ONE_A  = W'(1) << ALPHA_W;
    localparam logic [W-1:0] HALF_A = W'(1) << (ALPHA_W - 1);

    logic [W-1:0]     wt_o, wt_s;
    logic [W-1:0]     term_o_d, term_s_d, term_o_q, term_s_q;
    logic [W-1:0]     sum, rnd, scaled;
    logic [PIX_W-1:0] diff, result_d, result_q;

    // Non-alpha modes pass raw operands so stage 2 sees plain o and s.
    always_comb begin
        wt_s = W'(alpha);
        wt_o = ONE_A - wt_s;
        if (mode == BM_ALPHA) begin
            term_o_d = W'(orig) * wt_o;
            term_s_d = W'(sharp) * wt_s;
        end else begin
            term_o_d = W'(orig);
            term_s_d = W'(sharp);
        end
    end

    always_comb begin
        sum      = term_o_q + term_s_q;
        rnd      = sum + HALF_A;
        scaled   = rnd >> ALPHA_W;
        diff     = term_o_q[PIX_W-1:0] - term_s_q[PIX_W-1:0];
        result_d = '0;
        case (mode)
            BM_ADD_SAT: result_d = (sum > MAX) ? MAX[PIX_W-1:0] : sum[PIX_W-1:0];
            BM_SUB_SAT: result_d = (term_o_q >= term_s_q) ? diff : '0;
            BM_AVG:     result_d = sum[PIX_W:1];
            BM_ALPHA:   result_d = (scaled > MAX) ? MAX[PIX_W-1:0] : scaled[PIX_W-1:0];
            default:    result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            term_o_q <= '0;
            term_s_q <= '0;
            result_q <= '0;
        end else begin
            if (load1) begin
                term_o_q <= term_o_d;
                term_s_q <= term_s_d;
            end
            if (load2) begin
                result_q <= result_d;
            end
        end
    end

    assign result = result_q;

endmodule

// File: rtl/stream_pixel_blend.sv
// Streaming per-frame pixel blender: frame FSM, row/col tracking and a
// two-stage valid/ready pipeline wrapped around per-channel ALUs.
module stream_pixel_blend
    import blend_pkg::*;
#(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned ROWS     = 512,
    parameter int unsigned COLS     = 512,
    parameter int unsigned ALPHA_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MODE_W-1:0]  mode,
    input  logic [ALPHA_W-1:0] alpha,
    stream_pixel_blend_if.slave bus,
    output logic               busy,
    output logic               done
);
    localparam int unsigned DW    = CHANNELS * PIX_W;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    blend_state_e       state_q, state_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [ALPHA_W-1:0] alpha_q, alpha_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               v1_q, v1_d, eol1_q, eol1_d, eof1_q, eof1_d;
    logic               v2_q, v2_d, eol2_q, eol2_d, eof2_q, eof2_d;
    logic               adv2, in_xfer, last_col, last_pix;
    logic [DW-1:0]      orig_w, sharp_w, pix_w;

    // Stage 1 moves into stage 2 when stage 2 is empty or being drained.
    assign adv2        = v1_q && (!v2_q || bus.m_ready);
    assign bus.s_ready = (state_q == ST_RUN) && (!v1_q || adv2);
    assign in_xfer     = bus.s_valid && bus.s_ready;
    assign last_col    = (col_q == LAST_COL);
    assign last_pix    = last_col && (row_q == LAST_ROW);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        alpha_d = alpha_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    alpha_d = alpha;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_RUN: begin
                if (in_xfer && last_pix) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!v1_q && !v2_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (in_xfer) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_pix ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        v1_d   = in_xfer ? 1'b1 : (adv2 ? 1'b0 : v1_q);
        eol1_d = in_xfer ? last_col : eol1_q;
        eof1_d = in_xfer ? last_pix : eof1_q;
        v2_d   = adv2 ? 1'b1 : (bus.m_ready ? 1'b0 : v2_q);
        eol2_d = adv2 ? eol1_q : eol2_q;
        eof2_d = adv2 ? eof1_q : eof2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            alpha_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            v1_q    <= 1'b0;
            eol1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            v2_q    <= 1'b0;
            eol2_q  <= 1'b0;
            eof2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            alpha_q <= alpha_d;
            row_q   <= row_d;
            col_q   <= col_d;
            v1_q    <= v1_d;
            eol1_q  <= eol1_d;
            eof1_q  <= eof1_d;
            v2_q    <= v2_d;
            eol2_q  <= eol2_d;
            eof2_q  <= eof2_d;
        end
    end

    assign orig_w  = bus.orig_pix;
    assign sharp_w = bus.sharp_pix;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        blend_channel_alu #(
            .PIX_W  (PIX_W),
            .ALPHA_W(ALPHA_W)
        ) u_alu (
            .clk   (clk),
            .reset (reset),
            .load1 (in_xfer),
            .load2 (adv2),
            .mode  (mode_q),
            .alpha (alpha_q),
            .orig  (orig_w[c*PIX_W +: PIX_W]),
            .sharp (sharp_w[c*PIX_W +: PIX_W]),
            .result(pix_w[c*PIX_W +: PIX_W])
        );
    end

    assign bus.m_valid = v2_q;
    assign bus.m_pix   = pix_w;
    assign bus.m_eol   = eol2_q;
    assign bus.m_eof   = eof2_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_stream_pixel_blend.sv
// Randomised bench for stream_pixel_blend against a queue-based reference model.
module tb_stream_pixel_blend;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned ROWS     = 2;
    localparam int unsigned COLS     = 3;
    localparam int unsigned ALPHA_W  = 8;
    localparam int unsigned DW       = PIX_W * CHANNELS;
    localparam int unsigned NPIX     = ROWS * COLS;
    localparam int          MAXV     = (1 << PIX_W) - 1;
    localparam int          AONE     = 1 << ALPHA_W;

    typedef struct {
        logic [DW-1:0] pix;
        logic          eol;
        logic          eof;
    } out_t;

    logic               clk = 1'b0;
    logic               reset, start, busy, done;
    logic [1:0]         mode;
    logic [ALPHA_W-1:0] alpha;

    stream_pixel_blend_if #(.PIX_W(PIX_W), .CHANNELS(CHANNELS)) bus ();

    stream_pixel_blend #(
        .PIX_W   (PIX_W),
        .CHANNELS(CHANNELS),
        .ROWS    (ROWS),
        .COLS    (COLS),
        .ALPHA_W (ALPHA_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .mode (mode),
        .alpha(alpha),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    out_t          exp_q[$];
    logic [DW-1:0] in_o[$], in_s[$], out_log[$];
    int            total = 0, bad = 0, cyc = 0;
    int unsigned   mready_pct = 100, svalid_pct = 100;
    bit            start_req = 1'b0, stall_prev = 1'b0;
    int            req_mode, req_alpha, f_mode, f_alpha, f_idx;
    int            first_in, first_out;
    out_t          held;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference blend of one channel, straight from the mode definitions.
    function automatic int ref_chan(int m, int a, int o, int s);
        int r;
        case (m)
            0:       r = (o + s > MAXV) ? MAXV : o + s;
            1:       r = (o >= s) ? o - s : 0;
            2:       r = (o + s) / 2;
            default: begin
                r = (o * (AONE - a) + s * a + AONE / 2) / AONE;
                if (r > MAXV) r = MAXV;
            end
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_pix(int m, int a, logic [DW-1:0] o, logic [DW-1:0] s);
        logic [DW-1:0] r = '0;
        for (int c = 0; c < CHANNELS; c++)
            r[c*PIX_W +: PIX_W] = PIX_W'(ref_chan(m, a, int'(o[c*PIX_W +: PIX_W]),
                                                   int'(s[c*PIX_W +: PIX_W])));
        return r;
    endfunction

    function automatic logic [DW-1:0] rep(int v);
        logic [DW-1:0] r = '0;
        for (int c = 0; c < CHANNELS; c++) r[c*PIX_W +: PIX_W] = PIX_W'(v);
        return r;
    endfunction

    function automatic logic [DW-1:0] log_at(int i);
        if (i < out_log.size()) return out_log[i];
        return 'x;
    endfunction

    task automatic push_pair(logic [DW-1:0] o, logic [DW-1:0] s);
        in_o.push_back(o);
        in_s.push_back(s);
    endtask

    task automatic push_random(int n);
        for (int i = 0; i < n; i++) push_pair(DW'($urandom), DW'($urandom));
    endtask

    // One clock: drive just after the rising edge, observe at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        start     = start_req;
        start_req = 1'b0;
        if (start) begin
            mode  = 2'(req_mode);
            alpha = ALPHA_W'(req_alpha);
        end else begin
            mode  = 2'($urandom);
            alpha = ALPHA_W'($urandom);
        end
        bus.s_valid   = (in_o.size() > 0) && ($urandom_range(99) < svalid_pct);
        bus.orig_pix  = (in_o.size() > 0) ? in_o[0] : '0;
        bus.sharp_pix = (in_s.size() > 0) ? in_s[0] : '0;
        bus.m_ready   = ($urandom_range(99) < mready_pct);
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (start) begin
                f_mode  = req_mode;
                f_alpha = req_alpha;
                f_idx   = 0;
            end
            if (bus.s_valid && bus.s_ready) begin
                exp_q.push_back('{pix: ref_pix(f_mode, f_alpha, in_o[0], in_s[0]),
                                  eol: ((f_idx % COLS) == COLS - 1),
                                  eof: (f_idx == NPIX - 1)});
                f_idx++;
                void'(in_o.pop_front());
                void'(in_s.pop_front());
                if (first_in < 0) first_in = cyc;
            end
            if (stall_prev) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_pix", bus.m_pix, held.pix);
                check("hold_eol", bus.m_eol, held.eol);
                check("hold_eof", bus.m_eof, held.eof);
            end
            if (bus.m_valid && bus.m_ready) begin
                check("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("m_pix", bus.m_pix, exp_q[0].pix);
                    check("m_eol", bus.m_eol, exp_q[0].eol);
                    check("m_eof", bus.m_eof, exp_q[0].eof);
                    void'(exp_q.pop_front());
                end
                out_log.push_back(bus.m_pix);
                if (first_out < 0) first_out = cyc;
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            held.pix   = bus.m_pix;
            held.eol   = bus.m_eol;
            held.eof   = bus.m_eof;
        end
    endtask

    task automatic start_frame(int m, int a);
        out_log.delete();
        first_in  = -1;
        first_out = -1;
        req_mode  = m;
        req_alpha = a;
        start_req = 1'b1;
        tick();
        tick();
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
    endtask

    task automatic finish_frame(int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("frame_done", done, 1);
        check("model_drained", exp_q.size(), 0);
        check("frame_outputs", out_log.size(), NPIX);
    endtask

    task automatic run_frame(int m, int a, int budget);
        start_frame(m, a);
        finish_frame(budget);
    endtask

    int al[4] = '{0, 128, 255, 64};
    int ao[4] = '{100, 100, 0, 255};
    int as[4] = '{200, 200, 255, 255};
    int ae[4] = '{100, 150, 254, 255};

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = '0;
        alpha = '0;
        bus.s_valid   = 1'b0;
        bus.orig_pix  = '0;
        bus.sharp_pix = '0;
        bus.m_ready   = 1'b0;
        tick();
        tick();
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_pix", bus.m_pix, 0);
        check("rst_m_eol", bus.m_eol, 0);
        check("rst_m_eof", bus.m_eof, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        check("model_add_sat", ref_chan(0, 0, 200, 100), 255);
        check("model_sub_sat", ref_chan(1, 0, 50, 80), 0);
        check("model_alpha128", ref_chan(3, 128, 100, 200), 150);
        check("model_alpha255", ref_chan(3, 255, 0, 255), 254);

        push_pair(rep(200), rep(100));
        push_pair(rep(10), rep(20));
        push_random(4);
        run_frame(0, 0, 100);
        check("add_sat_200_100", log_at(0), rep(255));
        check("add_10_20", log_at(1), rep(30));
        check("latency", first_out - first_in, 2);
        tick();
        check("done_sticky", done, 1);

        push_pair(rep(50), rep(80));
        push_pair(rep(80), rep(50));
        push_random(4);
        run_frame(1, 0, 100);
        check("sub_50_80", log_at(0), rep(0));
        check("sub_80_50", log_at(1), rep(30));

        push_pair(rep(255), rep(254));
        push_pair(rep(3), rep(4));
        push_random(4);
        run_frame(2, 0, 100);
        check("avg_255_254", log_at(0), rep(254));
        check("avg_3_4", log_at(1), rep(3));

        for (int i = 0; i < 4; i++) begin
            push_pair(rep(ao[i]), rep(as[i]));
            push_random(5);
            run_frame(3, al[i], 100);
            check("alpha_literal", log_at(0), rep(ae[i]));
        end

        push_pair({8'd128, 8'd200, 8'd10}, {8'd128, 8'd100, 8'd5});
        push_random(5);
        run_frame(0, 0, 100);
        check("lanes_independent", log_at(0), 24'hFFFF0F);

        mready_pct = 50;
        for (int i = 0; i < 6; i++) begin
            push_random(6);
            run_frame(int'($urandom_range(3)), int'($urandom_range(255)), 300);
        end
        svalid_pct = 60;
        for (int i = 0; i < 2; i++) begin
            push_random(6);
            run_frame(int'($urandom_range(3)), int'($urandom_range(255)), 300);
        end
        svalid_pct = 100;
        mready_pct = 100;

        push_random(6);
        start_frame(3, 77);
        mready_pct = 0;
        repeat (5) tick();
        check("stall_s_ready_low", bus.s_ready, 0);
        check("stall_m_valid", bus.m_valid, 1);
        mready_pct = 100;
        finish_frame(100);

        push_random(6);
        start_frame(0, 0);
        begin
            int n = 0;
            while (f_idx < 3 && n < 50) begin
                tick();
                n++;
            end
        end
        check("three_accepted", f_idx, 3);
        svalid_pct = 0;
        tick();
        svalid_pct = 100;
        reset = 1'b1;
        tick();
        check("midrst_m_valid", bus.m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        in_o.delete();
        in_s.delete();
        push_random(6);
        run_frame(2, 0, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/stream_pixel_blend.md
Name: stream_pixel_blend

Overview:
- Streaming, parametrised successor to the whole-frame adder blend.
- Consumes paired original/sharpened pixels over a valid/ready stream and applies one of four per-frame blend modes per channel, including alpha-weighted.
- Emits a blended stream with end-of-line and end-of-frame markers, plus frame done.
- Sits between the sharpening filter output and the frame writer.

Parameters:
- PIX_W, 8, bits per channel.
- CHANNELS, 1, channels packed per pixel; channel c occupies bits [c*PIX_W +: PIX_W].
- ROWS, 512, rows per frame.
- COLS, 512, pixels per row.
- ALPHA_W, 8, alpha weight width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin frame; honoured only in IDLE or DONE
- mode  in  2  blend mode; latched on start
- alpha  in  ALPHA_W  blend weight; latched on start
- s_valid  in  1  input pixel pair valid
- s_ready  out  1  block accepts input pair
- orig_pix  in  CHANNELS*PIX_W  original pixel
- sharp_pix  in  CHANNELS*PIX_W  sharpened pixel
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts output
- m_pix  out  CHANNELS*PIX_W  blended pixel
- m_eol  out  1  qualifies m_pix as last pixel of a row
- m_eof  out  1  qualifies m_pix as last pixel of the frame
- busy  out  1  high in RUN and FLUSH
- done  out  1  high in DONE

Behaviour:
- Reset (synchronous, active-high): state IDLE. s_ready, m_valid, m_eol, m_eof, busy and done are 0; m_pix is 0; counters are 0; pipeline is emptied. Reset mid-frame discards all in-flight data; m_valid is low from the next cycle.
- FSM IDLE: on start, latch mode and alpha, clear row/col counters, go to RUN.
- FSM RUN: accept pixel pairs. When the pair at row ROWS-1, col COLS-1 is accepted, go to FLUSH.
- FSM FLUSH: s_ready=0. When the pipeline is empty and the final output has been accepted, go to DONE.
- FSM DONE: done=1 and stays high. start clears done and enters RUN for a new frame, with the same latch/clear as from IDLE. start in RUN or FLUSH is ignored.
- Handshakes: a transfer occurs when valid && ready. The input transfer is s_valid&&s_ready; the output transfer is m_valid&&m_ready.
- m_valid, m_pix, m_eol and m_eof hold stable while m_valid && !m_ready.
- s_ready is never combinationally dependent on s_valid.
- Pipeline: 2 registered stages. Stage 1 holds the operands and products; stage 2 holds the result.
- Latency: 2 cycles from input transfer to m_valid, with m_ready continuously high.
- Throughput: 1 pixel/cycle. A stage advances when the next stage is empty or draining this cycle; backpressure propagates with no data loss or duplication.
- s_ready = RUN && (stage 1 empty || stage 1 advancing).
- Counters: col increments on each input transfer. At COLS-1, col wraps to 0 and row increments.
- m_eol is set for col==COLS-1; m_eof for the last pixel of the frame. Both flags are carried through the pipeline with their pixel.
- Arithmetic is per channel, with o/s the unsigned channel values and MAX=2^PIX_W-1:
  - mode 0 ADD_SAT: min(o+s, MAX). Computed at PIX_W+1 bits.
  - mode 1 SUB_SAT: o>=s ? o-s : 0.
  - mode 2 AVG: (o+s)>>1, floor.
  - mode 3 ALPHA: (o*(2^ALPHA_W - alpha) + s*alpha + 2^(ALPHA_W-1)) >> ALPHA_W, rounding half up, clamped to MAX. alpha=0 yields o exactly.
  - Intermediates are PIX_W+ALPHA_W+1 bits.
- Changing mode/alpha inputs mid-frame has no effect.

Decomposition:
- Package blend_pkg holds:
  - typedef enum blend_mode_e {BM_ADD_SAT=0, BM_SUB_SAT=1, BM_AVG=2, BM_ALPHA=3}
  - typedef enum blend_state_e {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE}
  - localparam MODE_W=2
- Sub-module blend_channel_alu (PIX_W, ALPHA_W) holds the single-channel arithmetic. It is instantiated CHANNELS times in a generate loop; the split is register-friendly, with the multiply registered in stage 1 and the final add/shift/clamp in stage 2.

Test Plan (ROWS=2, COLS=3, PIX_W=8, CHANNELS=1 unless noted):
- ADD_SAT, m_ready=1: orig=200, sharp=100 -> m_pix=255, 2 cycles after accept. orig=10, sharp=20 -> 30. The 3rd and 6th outputs carry m_eol; only the 6th carries m_eof; done rises after the 6th transfer.
- SUB_SAT then AVG, over two frames: 50-80 -> 0; 80-50 -> 30. After DONE, start with mode=AVG: 255,254 -> 254; 3,4 -> 3.
- ALPHA: alpha=0: 100,200 -> 100. alpha=128: 100,200 -> 150. alpha=255: 0,255 -> 254. alpha=64: 255,255 -> 255, no overflow.
- Backpressure: random m_ready (~50%) with continuous s_valid -> output sequence equals the reference-model sequence exactly, with no drops or duplicates, and m_pix held stable while stalled. m_ready=0 for 5 cycles -> s_ready falls within 2 cycles.
- Reset mid-frame: synchronous reset after 3 accepts -> next cycle m_valid=0, busy=0, done=0. A new start produces a full 6-pixel frame with m_eol/m_eof correctly positioned.
- CHANNELS=3: orig {10,200,128}, sharp {5,100,128}, ADD_SAT -> {15,255,255}. Channels must be independent, with no carry between lanes.
